// File: rtl/counter_load_arbiter_if.sv
// Requester/counter-side bus of counter_load_arbiter: request/ack handshake,
// counter write port and status. master = requesters + counter, slave = arbiter.
interface counter_load_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    ack;
   logic [DW-1:0]      cnt_wdata;
   logic               cnt_wr;
   logic [DW-1:0]      cnt_data;
   logic [DW-1:0]      last_data;
   logic [2:0]         grant_id;
   logic               busy;

   modport master (
      output req, req_data, cnt_data,
      input  ack, cnt_wdata, cnt_wr, last_data, grant_id, busy
   );

   modport slave (
      input  req, req_data, cnt_data,
      output ack, cnt_wdata, cnt_wr, last_data, grant_id, busy
   );
endinterface

// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter sharing the loadable counter's write port among NREQ requesters.
// Define CNT_ARB_GUARD_EN to insert GUARD_CYC idle cycles after every write.
module counter_load_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int GUARD_CYC = 2
) (
   input logic                   clk,
   input logic                   reset,
   counter_load_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WRITE, ACK, GUARD} state_t;

   localparam logic [NREQ-1:0] ONE_HOT0   = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [7:0]      GUARD_LAST = 8'(GUARD_CYC - 1);

   state_t        state;
   logic [2:0]    rr_ptr;
   logic [DW-1:0] data_lat;
   logic [7:0]    guard_cnt;
   logic [3:0]    win;

   // Returns {found, index}: first set bit at or above ptr, wrapping to 0.
   function automatic logic [3:0] pick(input logic [NREQ-1:0] r, input logic [2:0] ptr);
      logic [3:0] res;
      int p;
      res = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         p = int'(ptr) + i;
         if (p >= NREQ) p = p - NREQ;
         if (r[p]) res = {1'b1, 3'(p)};
      end
      return res;
   endfunction

   // A requester sees its ack only at the next edge, so it is masked for that one grant decision.
   always_comb win = pick(bus.req & ~bus.ack, rr_ptr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         data_lat      <= '0;
         guard_cnt     <= '0;
         bus.ack       <= '0;
         bus.cnt_wr    <= 1'b0;
         bus.cnt_wdata <= '0;
         bus.last_data <= '0;
         bus.grant_id  <= '0;
         bus.busy      <= 1'b0;
      end else begin
         bus.ack       <= '0;
         bus.cnt_wr    <= 1'b0;
         bus.cnt_wdata <= '0;
         // The counter has absorbed the write by the cycle the ack is visible.
         if (|bus.ack) bus.last_data <= bus.cnt_data;
         case (state)
            IDLE: begin
               if (win[3]) begin
                  bus.grant_id <= win[2:0];
                  data_lat     <= bus.req_data[int'(win[2:0])*DW +: DW];
                  bus.busy     <= 1'b1;
                  state        <= WRITE;
               end
            end
            WRITE: begin
               bus.cnt_wr    <= 1'b1;
               bus.cnt_wdata <= data_lat;
               state         <= ACK;
            end
            ACK: begin
               bus.ack   <= ONE_HOT0 << bus.grant_id;
               rr_ptr    <= (bus.grant_id == 3'(NREQ - 1)) ? 3'd0 : bus.grant_id + 3'd1;
               guard_cnt <= GUARD_LAST;
`ifdef CNT_ARB_GUARD_EN
               state     <= GUARD;
`else
               bus.busy  <= 1'b0;
               state     <= IDLE;
`endif
            end
            GUARD: begin
               if (guard_cnt == 8'd0) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  guard_cnt <= guard_cnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_load_arbiter.sv
// Directed bench for counter_load_arbiter: table of single grants plus hand-written
// contention, fairness, late-drop and reset sequences. Honors CNT_ARB_GUARD_EN.
module tb_counter_load_arbiter;

`ifdef CNT_ARB_GUARD_EN
   localparam int GAP = 2;
`else
   localparam int GAP = 0;
`endif
   localparam int PERIOD = 3 + GAP;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] cnt_q;
   logic [3:0] ack_pre;
   logic       auto_drop = 1'b0;
   int         n_vec = 0;
   int         n_bad = 0;

   counter_load_arbiter_if #(.NREQ(4), .DW(8)) bus ();

   counter_load_arbiter #(.NREQ(4), .DW(8), .GUARD_CYC(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Plain loadable counter model.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else if (bus.cnt_wr) cnt_q <= bus.cnt_wdata;
   end
   assign bus.cnt_data = cnt_q;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [2:0]  gid;
      logic [7:0]  wdata;
      logic [3:0]  ack;
   } vec_t;

   vec_t vt [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; requesters with auto_drop release req after seeing their ack.
   task automatic tick();
      @(negedge clk);
      ack_pre = bus.ack;
      @(posedge clk);
      #1;
      if (auto_drop) bus.req = bus.req & ~ack_pre;
   endtask

   logic [3:0] ack_v[$];
   int         ack_t[$];
   logic [7:0] wr_v[$];

   task automatic record(input int ncyc);
      ack_v.delete(); ack_t.delete(); wr_v.delete();
      for (int t = 0; t < ncyc; t++) begin
         tick();
         if (bus.ack != 4'b0) begin
            ack_v.push_back(bus.ack);
            ack_t.push_back(t);
         end
         if (bus.cnt_wr) wr_v.push_back(bus.cnt_wdata);
      end
   endtask

   initial begin
      logic [3:0] exp_ack4 [4];
      logic [7:0] exp_wr4  [4];

      vt[0] = '{4'b0100, 32'h0055_0000, 3'd2, 8'h55, 4'b0100};
      vt[1] = '{4'b1001, 32'hA300_0010, 3'd3, 8'hA3, 4'b1000};
      vt[2] = '{4'b1001, 32'hA300_0010, 3'd0, 8'h10, 4'b0001};
      vt[3] = '{4'b0101, 32'h00C2_0001, 3'd2, 8'hC2, 4'b0100};
      vt[4] = '{4'b0011, 32'h0000_817E, 3'd0, 8'h7E, 4'b0001};
      vt[5] = '{4'b0011, 32'h0000_817E, 3'd1, 8'h81, 4'b0010};
      vt[6] = '{4'b1000, 32'hFF00_0000, 3'd3, 8'hFF, 4'b1000};

      bus.req = '0;
      bus.req_data = '0;
      repeat (2) tick();
      check("rst_busy",   32'(bus.busy),      0);
      check("rst_cnt_wr", 32'(bus.cnt_wr),    0);
      check("rst_ack",    32'(bus.ack),       0);
      check("rst_gid",    32'(bus.grant_id),  0);
      check("rst_wdata",  32'(bus.cnt_wdata), 0);
      check("rst_last",   32'(bus.last_data), 0);
      reset = 1'b1;

      repeat (3) tick();
      check("idle_busy",   32'(bus.busy),   0);
      check("idle_cnt_wr", 32'(bus.cnt_wr), 0);

      // Table: each requester set is dropped right after the grant, data scrambled.
      for (int i = 0; i < 7; i++) begin
         bus.req = vt[i].req;
         bus.req_data = vt[i].data;
         tick();
         check($sformatf("v%0d_busy", i), 32'(bus.busy), 1);
         check($sformatf("v%0d_gid", i), 32'(bus.grant_id), 32'(vt[i].gid));
         check($sformatf("v%0d_wr_early", i), 32'(bus.cnt_wr), 0);
         bus.req = '0;
         bus.req_data = 32'hDEAD_BEEF;
         tick();
         check($sformatf("v%0d_wr", i), 32'(bus.cnt_wr), 1);
         check($sformatf("v%0d_wdata", i), 32'(bus.cnt_wdata), 32'(vt[i].wdata));
         tick();
         check($sformatf("v%0d_ack", i), 32'(bus.ack), 32'(vt[i].ack));
         check($sformatf("v%0d_wr_off", i), 32'(bus.cnt_wr), 0);
         check($sformatf("v%0d_wdata_off", i), 32'(bus.cnt_wdata), 0);
         tick();
         check($sformatf("v%0d_ack_off", i), 32'(bus.ack), 0);
         check($sformatf("v%0d_last", i), 32'(bus.last_data), 32'(vt[i].wdata));
         repeat (GAP) tick();
      end

      // Contention: all four held, each drops after its own ack.
      exp_ack4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp_wr4  = '{8'h11, 8'h22, 8'h33, 8'h44};
      auto_drop = 1'b1;
      bus.req_data = 32'h4433_2211;
      bus.req = 4'b1111;
      record(30);
      check("cont_nack", 32'(ack_v.size()), 4);
      check("cont_nwr",  32'(wr_v.size()), 4);
      for (int i = 0; i < ack_v.size() && i < 4; i++)
         check($sformatf("cont_ack%0d", i), 32'(ack_v[i]), 32'(exp_ack4[i]));
      for (int i = 1; i < ack_t.size(); i++)
         check($sformatf("cont_gap%0d", i), 32'(ack_t[i] - ack_t[i-1]), 32'(PERIOD));
      for (int i = 0; i < wr_v.size() && i < 4; i++)
         check($sformatf("cont_wd%0d", i), 32'(wr_v[i]), 32'(exp_wr4[i]));
      check("cont_req_empty", 32'(bus.req), 0);

      // Fairness: move pointer to 3, then hold 1001 continuously.
      bus.req_data = 32'h0055_0000;
      bus.req = 4'b0100;
      repeat (6 + GAP) tick();
      auto_drop = 1'b0;
      bus.req_data = 32'hB300_00B0;
      bus.req = 4'b1001;
      exp_ack4 = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
      exp_wr4  = '{8'hB3, 8'hB0, 8'hB3, 8'hB0};
      record(4 * PERIOD);
      bus.req = '0;
      repeat (3 + GAP) tick();
      check("fair_nack", 32'(ack_v.size()), 4);
      for (int i = 0; i < ack_v.size() && i < 4; i++)
         check($sformatf("fair_ack%0d", i), 32'(ack_v[i]), 32'(exp_ack4[i]));
      for (int i = 0; i < wr_v.size() && i < 4; i++)
         check($sformatf("fair_wd%0d", i), 32'(wr_v[i]), 32'(exp_wr4[i]));
      check("fair_busy_end", 32'(bus.busy), 0);

      // Late drop: requester 1 releases req while its write is on the bus.
      bus.req_data = 32'h0000_5A00;
      bus.req = 4'b0010;
      ack_v.delete(); wr_v.delete();
      for (int t = 0; t < 10; t++) begin
         tick();
         if (bus.ack != 4'b0) ack_v.push_back(bus.ack);
         if (bus.cnt_wr) begin
            wr_v.push_back(bus.cnt_wdata);
            bus.req = '0;
         end
      end
      check("late_nwr",  32'(wr_v.size()), 1);
      check("late_nack", 32'(ack_v.size()), 1);
      if (ack_v.size() > 0) check("late_ack", 32'(ack_v[0]), 32'(4'b0010));
      if (wr_v.size() > 0) check("late_wd", 32'(wr_v[0]), 32'h5A);
      check("late_last", 32'(bus.last_data), 32'h5A);

      // Reset during the write: pointer is 2, so 0101 grants 2 first.
      bus.req_data = 32'h0077_0066;
      bus.req = 4'b0101;
      tick();
      check("rstw_gid", 32'(bus.grant_id), 2);
      tick();
      check("rstw_wr", 32'(bus.cnt_wr), 1);
      #1 reset = 1'b0;
      #1;
      check("rstw_wr_drop", 32'(bus.cnt_wr),    0);
      check("rstw_ack",     32'(bus.ack),       0);
      check("rstw_busy",    32'(bus.busy),      0);
      check("rstw_gid0",    32'(bus.grant_id),  0);
      check("rstw_last",    32'(bus.last_data), 0);
      #1 reset = 1'b1;
      tick();
      check("post_rst_gid",  32'(bus.grant_id), 0);
      check("post_rst_busy", 32'(bus.busy), 1);
      bus.req = '0;
      tick();
      check("post_rst_wd", 32'(bus.cnt_wdata), 32'h66);
      repeat (2) tick();
      check("post_rst_last", 32'(bus.last_data), 32'h66);
      repeat (2 + GAP) tick();
      check("post_rst_idle", 32'(bus.busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
